memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_pkg.sv | 17 +
 rtl/arb_picker.sv | 30 +++
 rtl/memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, requester
// ids and default bus widths.
package memory_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned LINE_WIDTH_DEF = 128;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Requester ids
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/arb_picker.sv
// Combinational two-way grant picker.
// Ports:
//   ic_req_i, dc_req_i : pending requests
//   last_grant_i       : requester granted most recently
//   rr_en_i            : 1 = round robin on ties, 0 = dc wins ties
//   valid_c_o          : at least one request pending (combinational)
//   grant_c_o          : winning requester id (combinational)
module arb_picker
  import memory_pkg::*;
(
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic last_grant_i,
  input  logic rr_en_i,
  output logic valid_c_o,
  output logic grant_c_o
);

  // Tie goes to the requester not served last, or to dc in fixed mode
  always_comb begin
    valid_c_o = ic_req_i | dc_req_i;
    grant_c_o = REQ_IC;
    if (ic_req_i && dc_req_i) begin
      grant_c_o = rr_en_i ? ~last_grant_i : REQ_DC;
    end else if (dc_req_i) begin
      grant_c_o = REQ_DC;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction-cache and data-cache line requests onto a single
// memory port, one transaction in flight at a time (IDLE -> MEM -> DONE).
// Build option: define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise dc always wins ties.
// Ports:
//   clk, reset                      : clock, async active-low reset
//   ic_req/ic_addr/ic_ready/ic_rdata: instruction-cache fill port
//   dc_req/dc_we/dc_addr/dc_wdata/
//   dc_ready/dc_rdata               : data-cache fill / write-back port
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ready/mem_rdata   : memory port
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_ready,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_ready,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  logic [1:0]            state_q,     state_d;
  logic                  win_q,       win_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] line_q,      line_d;
  logic                  ic_ready_q,  ic_ready_d;
  logic                  dc_ready_q,  dc_ready_d;

  logic                  last_grant;
  logic                  rr_en;
  logic                  valid_c;
  logic                  grant_c;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign rr_en      = 1'b1;
  assign last_grant = last_grant_q;

  // Remember who won each arbitration
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && valid_c) begin
      last_grant_d = grant_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= REQ_IC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign rr_en      = 1'b0;
  assign last_grant = REQ_IC;
`endif

  arb_picker u_picker (
    .ic_req_i     (ic_req),
    .dc_req_i     (dc_req),
    .last_grant_i (last_grant),
    .rr_en_i      (rr_en),
    .valid_c_o    (valid_c),
    .grant_c_o    (grant_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    line_d      = line_q;
    ic_ready_d  = 1'b0;
    dc_ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_c) begin
          win_d     = grant_c;
          mem_req_d = 1'b1;
          state_d   = ST_MEM;
          if (grant_c == REQ_DC) begin
            mem_we_d    = dc_we;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = ic_addr;
          end
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          // Write-backs return no data; keep the last fetched line visible
          if (!mem_we_q) begin
            line_d = mem_rdata;
          end
          ic_ready_d = (win_q == REQ_IC);
          dc_ready_d = (win_q == REQ_DC);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      win_q       <= REQ_IC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      line_q      <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      line_q      <= line_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
    end
  end

  assign ic_ready  = ic_ready_q;
  assign dc_ready  = dc_ready_q;
  assign ic_rdata  = line_q;
  assign dc_rdata  = line_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter.
module tb_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  localparam logic [LW-1:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [LW-1:0] LINE_B = 128'h11111111_22222222_33333333_44444444;
  localparam logic [LW-1:0] LINE_C = 128'h55555555_66666666_77777777_88888888;
  localparam logic [LW-1:0] LINE_D = 128'h0BADF00D_0BADF00D_12345678_9ABCDEF0;
  localparam logic [LW-1:0] LINE_E = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;
  localparam logic [LW-1:0] LINE_F = 128'hFEEDFACE_C0FFEE00_13579BDF_2468ACE0;
  localparam logic [LW-1:0] WB_A5  = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;

  logic          clk;
  logic          reset;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ready;
  logic [LW-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          dc_ready;
  logic [LW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;

  int n_cmp;
  int n_bad;

  memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ready  (ic_ready),
    .ic_rdata  (ic_rdata),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_ready  (dc_ready),
    .dc_rdata  (dc_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({mem_req, mem_we, ic_ready, dc_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, ic_ready, dc_ready});
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_wdata !== '0 || ic_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h want zeros", mem_addr, mem_wdata, ic_rdata);
    end
    #3 reset = 1'b1;
    step();
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: mem_req %b want 0", mem_req);
    end
  endtask

  task automatic test_ic_read();
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_1000;
    step();
    n_cmp++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL ic_issue: req/we %b addr %h want 10 00001000", {mem_req, mem_we}, mem_addr);
    end
    step();
    n_cmp++;
    if ({mem_req, ic_ready, dc_ready} !== 3'b100) begin
      n_bad++;
      $display("FAIL ic_wait: req/icr/dcr %b want 100", {mem_req, ic_ready, dc_ready});
    end
    step();
    mem_ready = 1'b1;
    mem_rdata = LINE_A;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({mem_req, ic_ready, dc_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL ic_ready: req/icr/dcr %b want 010", {mem_req, ic_ready, dc_ready});
    end
    n_cmp++;
    if (ic_rdata !== LINE_A) begin
      n_bad++;
      $display("FAIL ic_rdata: got %h want %h", ic_rdata, LINE_A);
    end
    ic_req = 1'b0;
    step();
    n_cmp++;
    if (ic_ready !== 1'b0 || ic_rdata !== LINE_A) begin
      n_bad++;
      $display("FAIL ic_pulse_end: icr %b rdata %h want 0 %h", ic_ready, ic_rdata, LINE_A);
    end
  endtask

  task automatic test_dc_write();
    step();
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 32'h0000_2000;
    dc_wdata = WB_A5;
    step();
    n_cmp++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h0000_2000 || mem_wdata !== WB_A5) begin
      n_bad++;
      $display("FAIL dc_issue: req/we %b addr %h wdata %h", {mem_req, mem_we}, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    mem_rdata = LINE_E;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({ic_ready, dc_ready, mem_req} !== 3'b010) begin
      n_bad++;
      $display("FAIL dc_ready: icr/dcr/req %b want 010", {ic_ready, dc_ready, mem_req});
    end
    n_cmp++;
    if (dc_rdata !== LINE_A) begin
      n_bad++;
      $display("FAIL dc_wb_line: got %h want %h", dc_rdata, LINE_A);
    end
    dc_req = 1'b0;
    dc_we  = 1'b0;
    step();
    n_cmp++;
    if ({ic_ready, dc_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL dc_pulse_end: icr/dcr %b want 00", {ic_ready, dc_ready});
    end
  endtask

  task automatic test_both();
    logic          first_dc;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] second_addr;
    logic [1:0]    first_rdy;
    logic [1:0]    second_rdy;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    first_dc = 1'b0;
`else
    first_dc = 1'b1;
`endif
    first_addr  = first_dc ? 32'h0000_4000 : 32'h0000_3000;
    second_addr = first_dc ? 32'h0000_3000 : 32'h0000_4000;
    first_rdy   = first_dc ? 2'b01 : 2'b10;
    second_rdy  = first_dc ? 2'b10 : 2'b01;
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_3000;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_4000;
    step();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== first_addr) begin
      n_bad++;
      $display("FAIL both_first_addr: req %b we %b addr %h want 1 0 %h", mem_req, mem_we, mem_addr, first_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = LINE_B;
    step();
    mem_ready = 1'b0;
    n_cmp++;
    if ({ic_ready, dc_ready} !== first_rdy || ic_rdata !== LINE_B) begin
      n_bad++;
      $display("FAIL both_first_ready: icr/dcr %b rdata %h want %b %h", {ic_ready, dc_ready}, ic_rdata, first_rdy, LINE_B);
    end
    if (first_dc) dc_req = 1'b0;
    else          ic_req = 1'b0;
    step();
    n_cmp++;
    if ({mem_req, ic_ready, dc_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL both_gap: req/icr/dcr %b want 000", {mem_req, ic_ready, dc_ready});
    end
    step();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== second_addr) begin
      n_bad++;
      $display("FAIL both_second_addr: req %b addr %h want 1 %h", mem_req, mem_addr, second_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = LINE_C;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({ic_ready, dc_ready} !== second_rdy || dc_rdata !== LINE_C) begin
      n_bad++;
      $display("FAIL both_second_ready: icr/dcr %b rdata %h want %b %h", {ic_ready, dc_ready}, dc_rdata, second_rdy, LINE_C);
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    step();
    n_cmp++;
    if ({mem_req, ic_ready, dc_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL both_end: req/icr/dcr %b want 000", {mem_req, ic_ready, dc_ready});
    end
  endtask

  task automatic test_reset_mid();
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_5000;
    step();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5000) begin
      n_bad++;
      $display("FAIL rst_mid_issue: req %b addr %h want 1 00005000", mem_req, mem_addr);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || ic_rdata !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_async: req %b addr %h rdata %h want 0 0 0", mem_req, mem_addr, ic_rdata);
    end
    ic_req    = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = LINE_E;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({mem_req, ic_ready, dc_ready} !== 3'b000) begin
        n_bad++;
        $display("FAIL rst_mid_silent[%0d]: req/icr/dcr %b want 000", i, {mem_req, ic_ready, dc_ready});
      end
    end
    ic_req  = 1'b1;
    ic_addr = 32'h0000_6000;
    step();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6000) begin
      n_bad++;
      $display("FAIL rst_after_issue: req %b addr %h want 1 00006000", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({ic_ready, dc_ready} !== 2'b10 || ic_rdata !== LINE_D) begin
      n_bad++;
      $display("FAIL rst_after_ready: icr/dcr %b rdata %h want 10 %h", {ic_ready, dc_ready}, ic_rdata, LINE_D);
    end
    ic_req = 1'b0;
    step();
  endtask

  task automatic test_stray_ready();
    step();
    mem_ready = 1'b1;
    mem_rdata = LINE_E;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({mem_req, ic_ready, dc_ready} !== 3'b000 || dc_rdata !== LINE_D) begin
      n_bad++;
      $display("FAIL stray_ignored: req/icr/dcr %b rdata %h want 000 %h", {mem_req, ic_ready, dc_ready}, dc_rdata, LINE_D);
    end
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_7000;
    step();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_7000 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_issue: req %b addr %h we %b want 1 00007000 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1;
    mem_rdata = LINE_F;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({ic_ready, dc_ready, mem_req} !== 3'b010 || dc_rdata !== LINE_F) begin
      n_bad++;
      $display("FAIL stray_dc_ready: icr/dcr/req %b rdata %h want 010 %h", {ic_ready, dc_ready, mem_req}, dc_rdata, LINE_F);
    end
    dc_req = 1'b0;
    step();
    n_cmp++;
    if ({ic_ready, dc_ready, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL stray_end: icr/dcr/req %b want 000", {ic_ready, dc_ready, mem_req});
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_ic_read();
    test_dc_write();
    test_both();
    test_reset_mid();
    test_stray_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
